// File: rtl/mem_readback_pkg.sv
// Shared types and constants for the block-RAM readback streamer.
package mem_readback_pkg;

  localparam int ADDR_W    = 32;
  localparam int CKSUM_ROT = 1;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ISSUE  = 2'd1;
  localparam state_t DRAIN  = 2'd2;
  localparam state_t FINISH = 2'd3;

  // Sideband carried with each read through the latency pipe and FIFO.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              last;
  } beat_tag_t;

  function automatic logic [31:0] cksum_step(input logic [31:0] acc, input logic [31:0] data);
    return {acc[31-CKSUM_ROT:0], acc[31:32-CKSUM_ROT]} ^ data;
  endfunction

endpackage

// File: rtl/mem_readback_streamer_fifo.sv
// Small synchronous FIFO of packed beats; accepts push and pop in the same cycle even when full.
module readback_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WID   = 49,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [WID-1:0] push_data,
  input  logic           pop,
  output logic [WID-1:0] head,
  output logic [CW-1:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WID-1:0] mem_r [DEPTH];
  logic [PW-1:0]  wr_r;
  logic [PW-1:0]  rd_r;
  logic [CW-1:0]  cnt_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WID{1'b0}};
      end
      wr_r  <= {PW{1'b0}};
      rd_r  <= {PW{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_r] <= push_data;
        wr_r        <= ptr_inc(wr_r);
      end
      if (pop) begin
        rd_r <= ptr_inc(rd_r);
      end
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign head  = mem_r[rd_r];
  assign count = cnt_r;

endmodule

// File: rtl/mem_readback_streamer.sv
// Sweeps the RAM read port over a wrapping address window and streams words out.
// Optional MEM_READBACK_CHECKSUM_EN adds a rotate-xor checksum port over the streamed data.
module mem_readback_streamer
  import mem_readback_pkg::*;
#(
  parameter int WID_MEM    = 16,
  parameter int DEPTH_MEM  = 1024,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [31:0]        count,
  output logic               busy,
  output logic               done,
  output logic [31:0]        mem_raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic [WID_MEM-1:0] m_data,
  output logic [31:0]        m_addr,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last
`ifdef MEM_READBACK_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam int          FW     = ADDR_W + 1 + WID_MEM;
  localparam int          CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_MEM);
  localparam logic [31:0] LAST_A  = 32'(DEPTH_MEM - 1);

  state_t      state_r;
  state_t      state_s;
  logic [31:0] addr_r;
  logic [31:0] count_r;
  logic [31:0] issued_r;
  logic        busy_r;
  logic        done_r;

  logic [RD_LAT-1:0] pv_r;
  logic [RD_LAT-1:0] pl_r;
  logic [31:0]       pa_r [RD_LAT];

  logic        accept_s;
  logic        issue_s;
  logic        issue_last_s;
  logic        xfer_s;
  logic        last_xfer_s;
  logic        done_ev_s;
  logic [31:0] issue_addr_s;
  logic [31:0] next_addr_s;
  logic [31:0] base_wrap_s;
  logic [31:0] inflight_s;
  logic [31:0] occ_s;

  beat_tag_t    push_tag_s;
  beat_tag_t    head_tag_s;
  logic [FW-1:0] fifo_head_s;
  logic [CW-1:0] fifo_cnt_s;

  assign accept_s    = start && (state_r == IDLE);
  assign xfer_s      = m_valid && m_ready;
  assign last_xfer_s = xfer_s && m_last;
  assign base_wrap_s = base_addr % DEPTH_L;

  // Credit: slots already promised (FIFO + reads in flight), less the beat leaving this cycle.
  always_comb begin
    inflight_s = 32'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + {31'd0, pv_r[i]};
    end
    occ_s = 32'(fifo_cnt_s) + inflight_s - (xfer_s ? 32'd1 : 32'd0);
  end

  // Issue decision; the first read goes out in the start cycle to save a cycle of latency.
  always_comb begin
    issue_s      = 1'b0;
    issue_last_s = 1'b0;
    issue_addr_s = addr_r;
    case (state_r)
      IDLE: begin
        issue_s      = accept_s && (count != 32'd0);
        issue_last_s = (count == 32'd1);
        issue_addr_s = accept_s ? base_wrap_s : addr_r;
      end
      ISSUE: begin
        issue_s      = (issued_r != count_r) && (occ_s < 32'(FIFO_DEPTH));
        issue_last_s = (issued_r == count_r - 32'd1);
        issue_addr_s = addr_r;
      end
      default: begin
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        issue_addr_s = addr_r;
      end
    endcase
    next_addr_s = (issue_addr_s == LAST_A) ? 32'd0 : issue_addr_s + 32'd1;
  end

  // Next-state logic; an empty sweep reports done from FINISH, a normal one on its last beat.
  always_comb begin
    state_s   = state_r;
    done_ev_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (count == 32'd0) ? FINISH : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if ((issue_s && issue_last_s) || (issued_r == count_r)) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (last_xfer_s) begin
          state_s   = FINISH;
          done_ev_s = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      FINISH: begin
        state_s   = IDLE;
        done_ev_s = (count_r == 32'd0);
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM, address generator, status flags and read-latency pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      addr_r   <= 32'd0;
      count_r  <= 32'd0;
      issued_r <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pv_r     <= {RD_LAT{1'b0}};
      pl_r     <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        pa_r[i] <= 32'd0;
      end
    end else begin
      state_r <= state_s;
      done_r  <= done_ev_s;
      if (accept_s) begin
        count_r  <= count;
        issued_r <= {31'd0, issue_s};
        busy_r   <= 1'b1;
      end else begin
        if (issue_s) begin
          issued_r <= issued_r + 32'd1;
        end
        if (done_ev_s) begin
          busy_r <= 1'b0;
        end
      end
      if (issue_s) begin
        addr_r <= next_addr_s;
      end
      pv_r[0] <= issue_s;
      pl_r[0] <= issue_s && issue_last_s;
      pa_r[0] <= issue_addr_s;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_r[i] <= pv_r[i-1];
        pl_r[i] <= pl_r[i-1];
        pa_r[i] <= pa_r[i-1];
      end
    end
  end

  assign push_tag_s = '{addr: pa_r[RD_LAT-1], last: pl_r[RD_LAT-1]};

  readback_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WID   (FW),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pv_r[RD_LAT-1]),
    .push_data ({push_tag_s, mem_dout}),
    .pop       (xfer_s),
    .head      (fifo_head_s),
    .count     (fifo_cnt_s)
  );

  assign head_tag_s = beat_tag_t'(fifo_head_s[FW-1:WID_MEM]);
  assign m_valid    = (fifo_cnt_s != {CW{1'b0}});
  assign m_data     = fifo_head_s[WID_MEM-1:0];
  assign m_addr     = head_tag_s.addr;
  assign m_last     = m_valid && head_tag_s.last;
  assign mem_raddr  = reset ? 32'd0 : issue_addr_s;
  assign busy       = busy_r;
  assign done       = done_r;

`ifdef MEM_READBACK_CHECKSUM_EN
  logic [31:0] checksum_r;

  // Rotate-xor accumulation over every transferred beat, cleared on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_r <= 32'd0;
    end else if (accept_s) begin
      checksum_r <= 32'd0;
    end else if (xfer_s) begin
      checksum_r <= cksum_step(checksum_r, 32'(m_data));
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Directed bench for mem_readback_streamer with a 1-cycle-latency RAM model holding mem[i]=i.
module tb_mem_readback_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] count;
  logic        busy;
  logic        done;
  logic [31:0] mem_raddr;
  logic [15:0] mem_dout;
  logic [15:0] m_data;
  logic [31:0] m_addr;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
`ifdef MEM_READBACK_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] tb_mem [1024];

  mem_readback_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout),
    .m_data    (m_data),
    .m_addr    (m_addr),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
`ifdef MEM_READBACK_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= tb_mem[mem_raddr[9:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep and follow it beat by beat until done; poke fires a stray start mid-sweep.
  task automatic run_sweep(input int base, input int cnt, input bit rnd, input int hold_at,
                           input bit poke);
    int          j = 0;
    int          first_t = -1;
    int          last_t = -1;
    bit          stalled = 1'b0;
    logic [15:0] pd = 16'd0;
    logic [31:0] pa = 32'd0;
    logic        pl = 1'b0;
    int          ea;
    base_addr = 32'(base);
    count     = 32'(cnt);
    start     = 1'b1;
    m_ready   = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    for (int t = 1; t < 3000 && j < cnt; t++) begin
      if (poke && t == 5) begin
        start     = 1'b1;
        base_addr = 32'd500;
        count     = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (rnd) begin
        m_ready = (t >= hold_at && t < hold_at + 20) ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        m_ready = 1'b1;
      end
      if (stalled) begin
        chk("valid_held", {63'd0, m_valid}, 64'd1);
        chk("data_held", {48'd0, m_data}, {48'd0, pd});
        chk("addr_held", {32'd0, m_addr}, {32'd0, pa});
        chk("last_held", {63'd0, m_last}, {63'd0, pl});
      end
      stalled = 1'b0;
      if (m_valid) begin
        if (first_t < 0) first_t = t;
        if (m_ready) begin
          ea = (base + j) % 1024;
          chk("beat_addr", {32'd0, m_addr}, 64'(ea));
          chk("beat_data", {48'd0, m_data}, 64'(ea));
          chk("beat_last", {63'd0, m_last}, {63'd0, (j == cnt - 1)});
          j++;
          last_t = t;
        end else begin
          stalled = 1'b1;
          pd = m_data;
          pa = m_addr;
          pl = m_last;
        end
      end
      cyc();
    end
    start   = 1'b0;
    chk("all_beats", 64'(j), 64'(cnt));
    chk("first_beat_cycle", 64'(first_t), 64'd2);
    if (!rnd) begin
      chk("back_to_back", 64'(last_t - first_t), 64'(cnt - 1));
    end
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("busy_clear", {63'd0, busy}, 64'd0);
    chk("no_extra_beat", {63'd0, m_valid}, 64'd0);
    cyc();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int j;
    for (int i = 0; i < 1024; i++) tb_mem[i] = 16'(i);
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = 32'd0;
    count     = 32'd0;
    m_ready   = 1'b0;
    cyc();
    cyc();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_last", {63'd0, m_last}, 64'd0);
    chk("rst_raddr", {32'd0, mem_raddr}, 64'd0);
    chk("rst_data", {48'd0, m_data}, 64'd0);
    chk("rst_addr", {32'd0, m_addr}, 64'd0);
    reset = 1'b0;
    cyc();
    chk("idle_raddr", {32'd0, mem_raddr}, 64'd0);

    // Straight sweep with a stray start mid-way, then a sweep across the top of memory.
    run_sweep(0, 16, 1'b0, 0, 1'b1);
    run_sweep(1020, 8, 1'b0, 0, 1'b0);

    // Zero-length sweep: busy only in the FINISH cycle, done two cycles after start.
    base_addr = 32'd7;
    count     = 32'd0;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    chk("zero_busy_c1", {63'd0, busy}, 64'd1);
    chk("zero_done_c1", {63'd0, done}, 64'd0);
    chk("zero_valid_c1", {63'd0, m_valid}, 64'd0);
    cyc();
    chk("zero_done_c2", {63'd0, done}, 64'd1);
    chk("zero_busy_c2", {63'd0, busy}, 64'd0);
    chk("zero_valid_c2", {63'd0, m_valid}, 64'd0);
    cyc();
    chk("zero_done_c3", {63'd0, done}, 64'd0);

    // Backpressure: random ready plus a 20-cycle stall.
    run_sweep(100, 32, 1'b1, 10, 1'b0);

    // Abort a 64-word sweep by reset while beat 5 is on the bus.
    base_addr = 32'd0;
    count     = 32'd64;
    start     = 1'b1;
    m_ready   = 1'b1;
    cyc();
    start = 1'b0;
    j = 0;
    for (int t = 0; t < 200 && !(m_valid && j == 5); t++) begin
      if (m_valid) j++;
      cyc();
    end
    chk("abort_at_beat5", {32'd0, m_addr}, 64'd5);
    reset = 1'b1;
    cyc();
    chk("abort_valid", {63'd0, m_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      cyc();
      chk("abort_no_done", {63'd0, done}, 64'd0);
      chk("abort_quiet", {63'd0, m_valid}, 64'd0);
    end
    run_sweep(0, 4, 1'b0, 0, 1'b0);
`ifdef MEM_READBACK_CHECKSUM_EN
    // Rotate-xor over data 0,1,2,3 gives 0,1,0,3.
    chk("checksum", {32'd0, checksum}, 64'h3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
